// File: rtl/serial_add_ctrl_if.sv
// Request/result bus for the bit-serial adder controller.
// The master issues operands and start; the slave returns status and result.
interface serial_add_ctrl_if #(
  parameter int WIDTH = 8
) ();

  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;

  modport master (
    output start, a, b, cin,
    input  busy, done, sum, cout
  );

  modport slave (
    input  start, a, b, cin,
    output busy, done, sum, cout
  );

endinterface

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder controller: feeds one operand bit pair per cycle, LSB first,
// through an external full-adder cell and assembles the WIDTH-bit result.
module serial_add_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  serial_add_ctrl_if.slave  bus,
  output logic              fa_a,
  output logic              fa_b,
  output logic              fa_cin,
  input  logic              fa_s,
  input  logic              fa_cout
);

  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  state_t           state_next;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] psum;
  logic [WIDTH-1:0] psum_shifted;
  logic [WIDTH-1:0] sum_q;
  logic             carry;
  logic             cout_q;
  logic [CW-1:0]    cnt;
  logic             accept;
  logic             last_bit;
  logic             busy;
  logic             done;

  assign accept   = (state == IDLE) && bus.start;
  assign last_bit = (cnt == CW'(WIDTH - 1));

  // New sum bit enters at the MSB; after WIDTH shifts the first bit sits at bit 0.
  assign psum_shifted = (psum >> 1) | {fa_s, {(WIDTH-1){1'b0}}};

  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    // NOTE: default assignment first so no path leaves state_next unassigned (no latch).
    state_next = state;
    case (state)
      IDLE:    if (bus.start) state_next = RUN;
      RUN:     if (last_bit)  state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Outputs are forced low while reset is held, even before the reset edge lands.
  always_comb begin
    busy   = 1'b0;
    done   = 1'b0;
    fa_a   = 1'b0;
    fa_b   = 1'b0;
    fa_cin = 1'b0;
    if (rst_n) begin
      case (state)
        RUN: begin
          busy   = 1'b1;
          fa_a   = a_sh[0];
          fa_b   = b_sh[0];
          fa_cin = carry;
        end
        DONE:    done = 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_sh   <= '0;
      b_sh   <= '0;
      carry  <= 1'b0;
      cnt    <= '0;
      psum   <= '0;
      sum_q  <= '0;
      cout_q <= 1'b0;
    end else if (accept) begin
      a_sh  <= bus.a;
      b_sh  <= bus.b;
      carry <= bus.cin;
      cnt   <= '0;
      psum  <= '0;
    end else if (state == RUN) begin
      psum  <= psum_shifted;
      a_sh  <= a_sh >> 1;
      b_sh  <= b_sh >> 1;
      carry <= fa_cout;
      cnt   <= cnt + CW'(1);
      // The published result changes only on the completing edge.
      if (last_bit) begin
        sum_q  <= psum_shifted;
        cout_q <= fa_cout;
      end
    end
  end

  assign bus.busy = busy;
  assign bus.done = done;
  assign bus.sum  = sum_q;
  assign bus.cout = cout_q;

endmodule
